// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: W-bit adder time-sharing one 4-bit ripple slice over NIBBLES cycles; ADDSEQ_SUB_EN adds a sub port for A-B.
module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
`ifdef ADDSEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [NIBBLES-1:0][3:0] ra, rb, s_r;
    logic [IW-1:0] idx;
    logic carry, neg;
    logic [3:0] na, nb, sn;
    logic [4:0] c;
`ifdef ADDSEQ_SUB_EN
    assign neg = sub;
`else
    assign neg = 1'b0;
`endif
    assign sum = s_r;
    assign na = ra[idx];
    assign nb = rb[idx];
    always_comb begin
        c[0] = carry;
        for (int i = 0; i < 4; i++) begin
            sn[i] = na[i] ^ nb[i] ^ c[i];
            c[i+1] = (na[i] & nb[i]) | (c[i] & (na[i] ^ nb[i]));
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra <= '0;
            rb <= '0;
            s_r <= '0;
            idx <= '0;
            carry <= 1'b0;
            cout <= 1'b0;
            ready <= 1'b1;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ra <= a;
                    rb <= b ^ {(4*NIBBLES){neg}};
                    carry <= neg | cin;
                    idx <= '0;
                    state <= RUN;
                    ready <= 1'b0;
                    busy <= 1'b1;
                end
                RUN: begin
                    s_r[idx] <= sn;
                    carry <= c[4];
                    idx <= idx + 1'b1;
                    if (idx == IW'(NIBBLES - 1)) begin
                        cout <= c[4];
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: vector table, hand-written corner sequences and random ops against an arithmetic model.
module tb_adder_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;
    typedef struct {
        logic [W-1:0] a, b;
        logic ci, s;
        logic [W-1:0] es;
        logic ec;
    } vec_t;
    logic clk = 1'b0, rst, start, cin, sub;
    logic [W-1:0] a, b, sum;
    logic ready, busy, done, cout;
    logic [W-1:0] prev_sum;
    logic prev_cout;
    int n_vec = 0, n_err = 0;
    vec_t tbl[$];
    always #5 clk = ~clk;
    adder_seq_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef ADDSEQ_SUB_EN
        .sub(sub),
`endif
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout)
    );
    function automatic logic [W:0] model(input logic [W-1:0] x, y, input logic ci, s);
        return s ? {1'b0, x} + {1'b0, ~y} + (W+1)'(1) : {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction
    task automatic chk(input string name, input logic [31:0] got, exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask
    task automatic onehot();
        n_vec++;
        if ($countones({ready, busy, done}) != 1) begin
            n_err++;
            $display("FAIL onehot: got ready/busy/done=%b expected exactly one high", {ready, busy, done});
        end
    endtask
    task automatic wait_ready();
        for (int i = 0; i < 20 && ready !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        chk("ready_wait", 32'(ready), 32'(1));
    endtask
    // Called #1 after the edge that accepted start; scrambles inputs to prove capture.
    task automatic finish_op(input logic [W:0] e);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
        chk("busy_accept", 32'(busy), 32'(1));
        onehot();
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            onehot();
            if (k == 1) begin
                chk("stale_hi", 32'(sum[W-1:4]), 32'(prev_sum[W-1:4]));
                chk("nib0", 32'(sum[3:0]), 32'(e[3:0]));
                chk("cout_hold", 32'(cout), 32'(prev_cout));
            end
            chk(k < N ? "done_early" : "done", 32'(done), 32'(k == N));
        end
        chk("sum", 32'(sum), 32'(e[W-1:0]));
        chk("cout", 32'(cout), 32'(e[W]));
        @(posedge clk);
        #1;
        chk("ready_after", 32'(ready), 32'(1));
        chk("done_pulse", 32'(done), 32'(0));
        chk("sum_hold", 32'(sum), 32'(e[W-1:0]));
        prev_sum = e[W-1:0];
        prev_cout = e[W];
    endtask
    task automatic run_op(input logic [W-1:0] x, y, input logic ci, s, input logic [W:0] e);
        wait_ready();
        @(negedge clk);
        a = x;
        b = y;
        cin = ci;
        sub = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        finish_op(e);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int dones;
        logic [W-1:0] x, y;
        logic ci, s;
        tbl.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
        tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1});
        tbl.push_back('{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0});
        tbl.push_back('{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1});
        tbl.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
        tbl.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1});
`ifdef ADDSEQ_SUB_EN
        tbl.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
        tbl.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
        tbl.push_back('{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1});
`endif
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        prev_sum = '0;
        prev_cout = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        chk("rst_cout", 32'(cout), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < tbl.size(); i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, {tbl[i].ec, tbl[i].es});
        // start held high through RUN and DONE must yield a single operation
        wait_ready();
        @(negedge clk);
        a = 16'h0001;
        b = 16'h0001;
        cin = 1'b0;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'hAAAA;
        dones = 0;
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (k == N) chk("hold_sum", 32'(sum), 32'h0002);
        end
        @(posedge clk);
        #1;
        chk("hold_dones", 32'(dones), 32'(1));
        chk("hold_ready", 32'(ready), 32'(1));
        chk("hold_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        prev_sum = 16'h0002;
        prev_cout = 1'b0;
        finish_op(17'h0AAAB);
        // asynchronous reset between edges in the middle of RUN
        wait_ready();
        @(negedge clk);
        a = 16'h1111;
        b = 16'h2222;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ready", 32'(ready), 32'(1));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_sum", 32'(sum), 32'(0));
        chk("arst_cout", 32'(cout), 32'(0));
        prev_sum = '0;
        prev_cout = 1'b0;
        #1;
        rst = 1'b0;
        a = 16'h0F0F;
        b = 16'h0101;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        finish_op(17'h01011);
        for (int i = 0; i < 40; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            ci = 1'($urandom);
`ifdef ADDSEQ_SUB_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            run_op(x, y, ci, s, model(x, y, ci, s));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter: NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal range 1..8).
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new addition; sampled only when ready=1.
REQ-005 a  input  W  operand A, captured on accepted start.
REQ-006 b  input  W  operand B, captured on accepted start.
REQ-007 cin  input  1  carry-in into nibble 0, captured on accepted start.
REQ-008 sub  input  1  subtract request, captured on accepted start; present only with ADDSEQ_SUB_EN.
REQ-009 ready  output  1  high in IDLE only.
REQ-010 busy  output  1  high in RUN only.
REQ-011 done  output  1  one-cycle pulse, high in DONE only.
REQ-012 sum  output  W  registered result.
REQ-013 cout  output  1  registered carry-out of the top nibble.

Function
REQ-014 Block SHALL contain exactly one 4-bit ripple-carry slice (four full-adder bit cells, sum = a^b^c, carry = ab | c(a^b)) and SHALL time-share it across all nibbles.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-016 IDLE: start=1 at a rising edge SHALL latch a, b, cin (and sub), clear nibble index to 0, load carry register with cin, go to RUN; start=0 stays in IDLE.
REQ-017 RUN: each edge SHALL add nibble[idx] of A and B plus carry register, write the 4-bit result to sum[4*idx+3:4*idx], store slice carry in carry register, increment idx.
REQ-018 RUN SHALL go to DONE on the edge processing idx = NIBBLES-1; cout SHALL be updated with that edge's slice carry.
REQ-019 DONE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-020 Latency: start accepted at edge T SHALL give done=1 in the cycle after edge T+NIBBLES; next start accepted no earlier than edge T+NIBBLES+2.
REQ-021 start while busy or done SHALL be ignored (not queued); a, b, cin changes after capture SHALL not affect the result.
REQ-022 sum and cout SHALL hold their values from DONE until the first RUN edge of the next operation; upper nibbles not yet rewritten keep stale values during RUN.
REQ-023 Arithmetic SHALL be modulo 2^W; cout is the true carry out of bit W-1.
REQ-024 ready, busy, done SHALL be mutually exclusive and exactly one SHALL be high at all times outside reset.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force state IDLE, idx 0, carry register 0, sum 0, cout 0, done 0, busy 0, ready 1.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; after deassertion the block SHALL accept start at the first following edge.

Configuration
REQ-027 Macro ADDSEQ_SUB_EN defined: sub port exists; sub=1 captured SHALL invert every B bit before the slice and force the initial carry to 1 (cin ignored), giving sum = A-B mod 2^W, cout=1 meaning no borrow.
REQ-028 Macro ADDSEQ_SUB_EN undefined: no sub port, no inverter logic; behaviour exactly as addition only.

Verification
REQ-029 NIBBLES=4, a=0x1234, b=0x4321, cin=0, start at edge T -> done=1 after edge T+4, sum=0x5555, cout=0, ready=1 the cycle after.
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all four nibbles).
REQ-031 a=0x00FF, b=0x0000, cin=1 -> sum=0x0100, cout=0.
REQ-032 Start 0x0001+0x0001, then hold start=1 with a=0xAAAA during RUN and DONE -> single done, sum=0x0002; second operation begins only after ready returns.
REQ-033 rst pulsed between clock edges during RUN -> outputs reach reset values before the next edge, no done pulse, fresh start then completes correctly.
REQ-034 ADDSEQ_SUB_EN defined, a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
